// File: rtl/gated_alu_pkg.sv
// Shared opcode encodings, instruction field positions and error-flag constants
// for the gated ALU core and its bus interface.
package gated_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_LS  = 4'd8;
    localparam logic [3:0] OP_RS  = 4'd9;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_SET  = 1'b1;

    // Instruction layout is {opcode[3:0], A[dw-1:0], B[dw-1:0]}; B sits at bit 0.
    function automatic int instr_w(input int dw);
        return 4 + 2 * dw;
    endfunction

    function automatic int op_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int a_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/gated_alu_core_if.sv
// Instruction-in / result-out valid-ready bus of the gated ALU core.
interface gated_alu_core_if
    import gated_alu_pkg::*;
#(
    parameter int DATA_W = 4
);
    localparam int INSTR_W = instr_w(DATA_W);

    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_result;
    logic                  out_err;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_result, out_err
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_result, out_err
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO for any DEPTH >= 2; pointers wrap by compare so non-power-of-two
// depths work. Read data is the head entry, visible combinationally.
module sync_fifo_param #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/gated_alu_core.sv
// Single-issue core: instruction FIFO feeding a registered ALU result stage, plus a
// clock-enable request for an external ICG. The core never gates its own clk.
module gated_alu_core
    import gated_alu_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int DEPTH       = 64,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    gated_alu_core_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    input  logic                       clock_disable,
    output logic                       clk_en
);
    localparam int INSTR_W = instr_w(DATA_W);
    localparam int RES_W   = 2 * DATA_W;
    localparam int OP_LSB  = op_lsb(DATA_W);
    localparam int A_LSB   = a_lsb(DATA_W);
    localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    logic               push, pop, idle;
    logic [INSTR_W-1:0] head;
    logic [3:0]         op;
    logic [RES_W-1:0]   a_ext, b_ext, alu_res;
    logic               alu_err;
    logic               out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [RES_W-1:0]   out_result_q, out_result_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

    assign bus.in_ready = !fifo_full;
    assign push = bus.in_valid && !fifo_full;
    // The result register frees up in the same cycle the sink takes it.
    assign pop  = !fifo_empty && (!out_valid_q || bus.out_ready);

    sync_fifo_param #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_instr),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign op    = head[OP_LSB +: 4];
    assign a_ext = {{DATA_W{1'b0}}, head[A_LSB +: DATA_W]};
    assign b_ext = {{DATA_W{1'b0}}, head[DATA_W-1:0]};

    always_comb begin
        alu_res = '0;
        alu_err = ERR_NONE;
        unique case (op)
            OP_ADD: alu_res = a_ext + b_ext;
            OP_SUB: alu_res = a_ext - b_ext;
            OP_MUL: alu_res = a_ext * b_ext;
            OP_DIV: begin
                if (b_ext == '0) begin
                    alu_res = '1;
                    alu_err = ERR_SET;
                end else begin
                    alu_res = a_ext / b_ext;
                end
            end
            OP_AND: alu_res = a_ext & b_ext;
            OP_OR:  alu_res = a_ext | b_ext;
            OP_XOR: alu_res = a_ext ^ b_ext;
            OP_NOT: alu_res = {{DATA_W{1'b0}}, ~a_ext[DATA_W-1:0]};
            OP_LS:  alu_res = a_ext << 1;
            OP_RS:  alu_res = a_ext >> 1;
            default: begin
                alu_res = '0;
                alu_err = ERR_SET;
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_res;
            out_err_d    = alu_err;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    assign idle = fifo_empty && !out_valid_q && !bus.in_valid;

    always_comb begin
        idle_cnt_d = '0;
        if (idle) idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    end

    // in_valid bypasses the counter so a new instruction wakes the clock immediately.
    assign clk_en = !(clock_disable && (idle_cnt_q == IDLE_MAX) && !bus.in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_gated_alu_core.sv
// Scoreboard bench for gated_alu_core: a 64-deep and a 5-deep instance share clk/rst.
module tb_gated_alu_core;
    import gated_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clock_disable = 1'b0;
    always #5 clk = ~clk;

    gated_alu_core_if #(.DATA_W(4)) bus ();
    gated_alu_core_if #(.DATA_W(4)) bus5 ();

    logic [6:0] cnt;
    logic [2:0] cnt5;
    logic       empty, full, clk_en, empty5, full5, clk_en5;

    gated_alu_core #(.DATA_W(4), .DEPTH(64), .IDLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .fifo_count(cnt), .fifo_empty(empty),
        .fifo_full(full), .clock_disable(clock_disable), .clk_en(clk_en)
    );

    gated_alu_core #(.DATA_W(4), .DEPTH(5), .IDLE_CYCLES(4)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .fifo_count(cnt5), .fifo_empty(empty5),
        .fifo_full(full5), .clock_disable(clock_disable), .clk_en(clk_en5)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0] q[$];
    logic [8:0] q5[$];

    typedef struct {
        logic [3:0] op, a, b;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] res, input logic err);
        if (bus.in_ready) q.push_back({err, res});
        bus.in_valid = 1'b1;
        bus.in_instr = {op, a, b};
        step();
    endtask

    task automatic push5(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] res, input logic err);
        if (bus5.in_ready) q5.push_back({err, res});
        bus5.in_valid = 1'b1;
        bus5.in_instr = {op, a, b};
        step();
    endtask

    task automatic drain();
        int k = 0;
        bus.out_ready  = 1'b1;
        bus5.out_ready = 1'b1;
        while ((q.size() != 0 || q5.size() != 0) && k < 500) begin
            step();
            k++;
        end
        n_chk++;
        if (q.size() != 0 || q5.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q.size(), q5.size());
        end
        step();
        step();
    endtask

    // Monitors: compare each accepted result and require stalled outputs to hold.
    logic       stall, stall5;
    logic [8:0] held, held5, e, e5;

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (stall) chk("hold64", 32'({bus.out_err, bus.out_result}), 32'(held));
            if (bus.out_ready) begin
                stall = 1'b0;
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result64: got %0h with nothing expected", {bus.out_err, bus.out_result});
                end else begin
                    e = q.pop_front();
                    if ({bus.out_err, bus.out_result} !== e) begin
                        n_fail++;
                        $display("FAIL result64: got %0h, expected %0h", {bus.out_err, bus.out_result}, e);
                    end
                end
            end else begin
                stall = 1'b1;
                held  = {bus.out_err, bus.out_result};
            end
        end else begin
            stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus5.out_valid) begin
            if (stall5) chk("hold5", 32'({bus5.out_err, bus5.out_result}), 32'(held5));
            if (bus5.out_ready) begin
                stall5 = 1'b0;
                n_chk++;
                if (q5.size() == 0) begin
                    n_fail++;
                    $display("FAIL result5: got %0h with nothing expected", {bus5.out_err, bus5.out_result});
                end else begin
                    e5 = q5.pop_front();
                    if ({bus5.out_err, bus5.out_result} !== e5) begin
                        n_fail++;
                        $display("FAIL result5: got %0h, expected %0h", {bus5.out_err, bus5.out_result}, e5);
                    end
                end
            end else begin
                stall5 = 1'b1;
                held5  = {bus5.out_err, bus5.out_result};
            end
        end else begin
            stall5 = 1'b0;
        end
    end

    initial begin
        stall = 1'b0; stall5 = 1'b0;
        bus.in_valid = 1'b0;  bus.in_instr = '0;  bus.out_ready = 1'b0;
        bus5.in_valid = 1'b0; bus5.in_instr = '0; bus5.out_ready = 1'b0;
        vt = '{
            '{OP_DIV, 4'h9, 4'h0, 8'hFF, 1'b1},
            '{4'hC,   4'h3, 4'h3, 8'h00, 1'b1},
            '{OP_SUB, 4'h2, 4'h5, 8'hFD, 1'b0},
            '{OP_ADD, 4'hF, 4'hF, 8'h1E, 1'b0},
            '{OP_MUL, 4'hF, 4'hF, 8'hE1, 1'b0},
            '{OP_DIV, 4'h9, 4'h2, 8'h04, 1'b0},
            '{OP_AND, 4'hC, 4'hA, 8'h08, 1'b0},
            '{OP_OR,  4'hC, 4'hA, 8'h0E, 1'b0},
            '{OP_XOR, 4'hC, 4'hA, 8'h06, 1'b0},
            '{OP_NOT, 4'h5, 4'h0, 8'h0A, 1'b0},
            '{OP_LS,  4'hF, 4'h0, 8'h1E, 1'b0},
            '{OP_RS,  4'h9, 4'h0, 8'h04, 1'b0},
            '{4'hF,   4'h1, 4'h1, 8'h00, 1'b1},
            '{OP_SUB, 4'h0, 4'h1, 8'hFF, 1'b0},
            '{OP_DIV, 4'h7, 4'hF, 8'h00, 1'b0}
        };

        // Reset state
        repeat (2) step();
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_clk_en", 32'(clk_en), 32'd1);
        rst = 1'b0;

        // Single ADD: out_valid two edges after the push edge
        bus.out_ready = 1'b1;
        push(OP_ADD, 4'd3, 4'd5, 8'd8, 1'b0);
        bus.in_valid = 1'b0;
        chk("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_edge1_count", 32'(cnt), 32'd1);
        step();
        chk("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_edge2_result", 32'(bus.out_result), 32'd8);
        chk("lat_edge2_err", 32'(bus.out_err), 32'd0);
        step();

        // Opcode table with a toggling sink
        for (int i = 0; i < 15; i++) begin
            bus.out_ready = (i % 2) == 0;
            push(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].err);
        end
        bus.in_valid = 1'b0;
        drain();

        // Fill 64-deep FIFO under backpressure (first entry sits in the result register)
        bus.out_ready = 1'b0;
        for (int i = 0; i < 65; i++)
            push(OP_ADD, 4'(i % 16), 4'(i / 16), 8'(i % 16 + i / 16), 1'b0);
        chk("full_count", 32'(cnt), 32'd64);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        bus.in_instr = {OP_XOR, 4'hF, 4'hF};
        step();
        chk("full_push_dropped", 32'(cnt), 32'd64);
        // Pop with in_valid still high while full: push stays blocked
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("full_pop_count", 32'(cnt), 32'd63);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        drain();
        chk("drained_count", 32'(cnt), 32'd0);
        chk("drained_empty", 32'(empty), 32'd1);

        // DEPTH=5: fill, pop-while-full, then wrap pointers several times
        bus5.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push5(OP_ADD, 4'(i), 4'd1, 8'(i + 1), 1'b0);
        chk("d5_full", 32'(full5), 32'd1);
        chk("d5_count", 32'(cnt5), 32'd5);
        chk("d5_in_ready", 32'(bus5.in_ready), 32'd0);
        bus5.out_ready = 1'b1;
        step();
        bus5.in_valid = 1'b0;
        chk("d5_pop_count", 32'(cnt5), 32'd4);
        for (int i = 0; i < 12; i++) begin
            bus5.out_ready = (i % 3) != 0;
            push5(OP_SUB, 4'(i), 4'd3, 8'(i - 3), 1'b0);
        end
        bus5.in_valid = 1'b0;
        drain();

        // Reset with 10 queued, a held result and a push in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) push(OP_OR, 4'(i), 4'd0, 8'(i), 1'b0);
        chk("pre_rst_count", 32'(cnt), 32'd10);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        q.delete();
        chk("mid_rst_count", 32'(cnt), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_result", 32'(bus.out_result), 32'd0);
        chk("mid_rst_clk_en", 32'(clk_en), 32'd1);

        // Clock-enable: gate after 4 idle cycles, combinational wake
        bus.in_valid = 1'b0;
        clock_disable = 1'b1;
        step();
        rst = 1'b0;
        chk("ce_idle0", 32'(clk_en), 32'd1);
        repeat (3) step();
        chk("ce_idle3", 32'(clk_en), 32'd1);
        step();
        chk("ce_idle4", 32'(clk_en), 32'd0);
        chk("ce_idle4_d5", 32'(clk_en5), 32'd0);
        repeat (2) step();
        chk("ce_saturated", 32'(clk_en), 32'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("ce_wake_in_valid", 32'(clk_en), 32'd1);
        bus.in_valid = 1'b0;
        #1;
        chk("ce_regate", 32'(clk_en), 32'd0);
        clock_disable = 1'b0;
        #1;
        chk("ce_disable_low", 32'(clk_en), 32'd1);
        step();

        n_chk++;
        if (q.size() != 0 || q5.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d/%0d results never seen, expected 0", q.size(), q5.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
